ws_weight_loader: RTL and testbench

- Writer-side controller for the weight-stationary array's weight-load interface.
- Accepts one weight vector per array row from the weight buffer over a valid/ready handshake and stores ROWS vectors locally.
- Then drives the top edge of every column with weight_we held high for exactly ROWS cycles, in bottom-row-first order.
- When the pulse ends, PE row k of each column holds the weight for row k; a done pulse then lets the activation feeder start.

---
 rtl/ws_weight_loader_pkg.sv | 21 ++
 rtl/weight_row_buffer.sv | 27 ++
 rtl/ws_weight_loader.sv | 102 ++++++++++
 tb/tb_ws_weight_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws_weight_loader_pkg.sv
// Shared types and helpers for the weight-stationary weight loader.
// Holds the FSM encoding, counter sizing and the lane-slice convention for COLS*D_W buses.
package ws_weight_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Lane c of a COLS*D_W bus occupies bits [lane_lo(c, D_W) +: D_W].
  function automatic int lane_lo(input int lane, input int d_w);
    return lane * d_w;
  endfunction

  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/weight_row_buffer.sv
// ROWS x WIDTH register file holding one weight tile.
// One synchronous write port and one combinational read port.
module weight_row_buffer
  import ws_weight_loader_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int WIDTH = 32,
  parameter int AW    = cnt_width(ROWS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ROWS];

  // NOTE: storage has no reset; every row is rewritten by FILL before SHIFT reads it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ws_weight_loader.sv
// Collects ROWS weight vectors, then streams them bottom-row-first into the PE columns
// with weight_we held for exactly ROWS cycles, followed by a one-cycle done pulse.
module ws_weight_loader
  import ws_weight_loader_pkg::*;
#(
  parameter int D_W  = 8,
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              abort,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [COLS*D_W-1:0] w_data,
  output logic              weight_we,
  output logic [COLS*D_W-1:0] weight_out,
  output logic              busy,
  output logic              done
);

  localparam int CW = cnt_width(ROWS);
  localparam int VW = COLS * D_W;
  localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

  state_t        state, state_next;
  logic [CW-1:0] row_cnt, shift_cnt;
  logic [VW-1:0] rd_data;
  logic          wr_en;
  logic          shifting;

  assign w_ready  = (state == FILL);
  assign busy     = (state != IDLE);
  assign wr_en    = w_ready & w_valid & ~abort;
  assign shifting = (state == SHIFT) & ~abort;

  // Reading from the bottom row first lets the column shift chain settle row k on buf[k].
  weight_row_buffer #(
    .ROWS (ROWS),
    .WIDTH(VW),
    .AW   (CW)
  ) u_buf (
    .clk  (clk),
    .we   (wr_en),
    .waddr(row_cnt),
    .wdata(w_data),
    .raddr(LAST - shift_cnt),
    .rdata(rd_data)
  );

  // NOTE: state_next is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (load_start) state_next = FILL;
        FILL:    if (wr_en && row_cnt == LAST) state_next = SHIFT;
        SHIFT:   if (shift_cnt == LAST) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt   <= '0;
      shift_cnt <= '0;
    end else if (abort) begin
      row_cnt   <= '0;
      shift_cnt <= '0;
    end else begin
      if (wr_en)
        row_cnt <= (row_cnt == LAST) ? '0 : row_cnt + CW'(1);
      if (state == SHIFT)
        shift_cnt <= (shift_cnt == LAST) ? '0 : shift_cnt + CW'(1);
    end
  end

  // Registered edge outputs: high/valid on the ROWS cycles after each SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_we  <= 1'b0;
      weight_out <= '0;
      done       <= 1'b0;
    end else begin
      weight_we  <= shifting;
      weight_out <= shifting ? rd_data : '0;
      done       <= (state == DONE) & ~abort;
    end
  end

endmodule

// File: tb/tb_ws_weight_loader.sv
// Scoreboard bench for ws_weight_loader: a ROWS=4 instance with a behavioural 4x1 PE
// column attached to lane 0, plus a ROWS=1 instance.
module tb_ws_weight_loader;

  typedef struct {
    bit          is_done;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int          cyc;
  int          checks;
  int          failures;

  logic        load_start, abort, w_valid, w_ready, weight_we, busy, done;
  logic [31:0] w_data, weight_out;

  logic        ls1, ab1, wv1, wr1, we1, busy1, done1;
  logic [31:0] wd1, wo1;

  exp_t        sb4[$];
  exp_t        sb1[$];

  logic [7:0]  pe_w  [4];
  logic [7:0]  pe_f  [4];
  logic [7:0]  pe_in [4];

  ws_weight_loader #(.D_W(8), .ROWS(4), .COLS(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .abort(abort),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .weight_we(weight_we), .weight_out(weight_out), .busy(busy), .done(done)
  );

  ws_weight_loader #(.D_W(8), .ROWS(1), .COLS(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_start(ls1), .abort(ab1),
    .w_valid(wv1), .w_ready(wr1), .w_data(wd1),
    .weight_we(we1), .weight_out(wo1), .busy(busy1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural PE column: forward in_weight with one-cycle delay, latch it while weight_we.
  always_comb begin
    pe_in[0] = weight_out[7:0];
    for (int k = 1; k < 4; k++) pe_in[k] = pe_f[k-1];
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      pe_f[k] <= pe_in[k];
      if (weight_we) pe_w[k] <= pe_in[k];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rep(input logic [7:0] v);
    return {4{v}};
  endfunction

  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n) begin
      if (weight_we || done) begin
        if (sb4.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb4_unexpected: we=%b done=%b out=%h at cycle %0d, expected no event",
                   weight_we, done, weight_out, cyc);
        end else begin
          e = sb4.pop_front();
          check("sb4_cycle", cyc, e.cyc);
          check("sb4_we", {31'b0, weight_we}, {31'b0, !e.is_done});
          check("sb4_done", {31'b0, done}, {31'b0, e.is_done});
          check("sb4_data", weight_out, e.data);
        end
      end else begin
        check("sb4_idle_out", weight_out, 32'h0);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n) begin
      if (we1 || done1) begin
        if (sb1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb1_unexpected: we=%b done=%b out=%h at cycle %0d, expected no event",
                   we1, done1, wo1, cyc);
        end else begin
          e = sb1.pop_front();
          check("sb1_cycle", cyc, e.cyc);
          check("sb1_we", {31'b0, we1}, {31'b0, !e.is_done});
          check("sb1_done", {31'b0, done1}, {31'b0, e.is_done});
          check("sb1_data", wo1, e.data);
        end
      end else begin
        check("sb1_idle_out", wo1, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) tick();
  endtask

  task automatic start(output int c);
    c = cyc;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Drives one tile: bit i of pat is w_valid in FILL cycle i; lanes carry base+row on
  // handshakes and 8'hEE otherwise. Queues n_we stream beats (+ done) stamped from the
  // cycle of the last handshake.
  task automatic fill(input logic [7:0] base, input logic [15:0] pat, input int len,
                      input int n_we, input bit with_done, output int h);
    int row = 0;
    for (int i = 0; i < len; i++) begin
      w_valid = pat[i];
      w_data  = pat[i] ? rep(base + 8'(row)) : rep(8'hEE);
      check("fill_ready", {31'b0, w_ready}, 32'h1);
      check("fill_we_low", {31'b0, weight_we}, 32'h0);
      tick();
      if (pat[i]) row++;
    end
    w_valid = 1'b0;
    w_data  = '0;
    h = cyc - 1;
    for (int t = 0; t < n_we; t++)
      sb4.push_back('{1'b0, rep(base + 8'(3 - t)), h + 2 + t});
    if (with_done) sb4.push_back('{1'b1, 32'h0, h + 6});
  endtask

  task automatic check_pe(input string tag, input logic [7:0] base);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_pe%0d", tag, k), {24'h0, pe_w[k]}, {24'h0, base + 8'(k)});
  endtask

  initial begin : stim
    int c, h, c2;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    load_start = 1'b0; abort = 1'b0; w_valid = 1'b0; w_data = '0;
    ls1 = 1'b0; ab1 = 1'b0; wv1 = 1'b0; wd1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", {31'b0, weight_we}, 32'h0);
    check("rst_out", weight_out, 32'h0);
    check("rst_ready", {31'b0, w_ready}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst1_we", {31'b0, we1}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic load
    start(c);
    fill(8'h10, 16'h000F, 4, 4, 1'b1, h);
    check("basic_fill_len", h - c, 4);
    wait_cycle(h + 6);
    check("basic_busy_at_done", {31'b0, busy}, 32'h0);
    check_pe("basic", 8'h10);
    tick();

    // Stalled FILL: w_valid 1,0,0,1,0,1,1
    start(c);
    fill(8'h40, 16'b1101001, 7, 4, 1'b1, h);
    wait_cycle(h + 6);
    check_pe("stall", 8'h40);
    tick();

    // Ignored load_start during SHIFT, then back-to-back tile from the done cycle
    start(c);
    fill(8'h50, 16'h000F, 4, 4, 1'b1, h);
    wait_cycle(h + 2);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    wait_cycle(h + 6);
    start(c2);
    fill(8'h60, 16'h000F, 4, 4, 1'b1, h);
    check("b2b_start_cycle", h - c2, 4);
    wait_cycle(h + 6);
    check_pe("b2b", 8'h60);
    tick();

    // Abort on the 2nd weight_we cycle
    start(c);
    fill(8'h30, 16'h000F, 4, 2, 1'b0, h);
    wait_cycle(h + 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_we", {31'b0, weight_we}, 32'h0);
    check("abort_out", weight_out, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    wait_cycle(h + 12);
    start(c);
    fill(8'h20, 16'h000F, 4, 4, 1'b1, h);
    wait_cycle(h + 6);
    check_pe("after_abort", 8'h20);
    tick();

    // Async reset mid-FILL after 2 handshakes
    start(c);
    fill(8'h90, 16'h0003, 2, 0, 1'b0, h);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we", {31'b0, weight_we}, 32'h0);
    check("arst_out", weight_out, 32'h0);
    check("arst_ready", {31'b0, w_ready}, 32'h0);
    check("arst_busy", {31'b0, busy}, 32'h0);
    check("arst_done", {31'b0, done}, 32'h0);
    #4;
    rst_n = 1'b1;
    tick();
    start(c);
    fill(8'hA0, 16'h000F, 4, 4, 1'b1, h);
    wait_cycle(h + 6);
    check_pe("after_rst", 8'hA0);
    tick();

    // ROWS=1 instance: single vector 8'h7F per lane
    c = cyc;
    ls1 = 1'b1;
    tick();
    ls1 = 1'b0;
    wv1 = 1'b1;
    wd1 = rep(8'h7F);
    check("r1_ready", {31'b0, wr1}, 32'h1);
    tick();
    wv1 = 1'b0;
    wd1 = '0;
    h = cyc - 1;
    sb1.push_back('{1'b0, rep(8'h7F), h + 2});
    sb1.push_back('{1'b1, 32'h0, h + 3});
    wait_cycle(h + 6);

    check("sb4_drained", sb4.size(), 0);
    check("sb1_drained", sb1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
